// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
//   Shared layout definition for the Hamming(21,16) code, used by both the
//   encoder and the decoder so that both ends agree on bit placement.
//   - DATA_W / PAR_W / CODE_W : payload, parity and codeword widths
//   - data_pos(idx)           : Hamming position (1..21) of payload bit idx
//   - syn_mask(j)             : codeword bits covered by parity/syndrome bit j
//   - calc_syndrome(cw)       : 5-bit syndrome of a codeword
//   - encode(d)               : 16-bit payload -> 21-bit codeword
//   Codeword bit k-1 holds Hamming position k.
// ---------------------------------------------------------------------------
package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int PAR_W  = 5;
  localparam int CODE_W = DATA_W + PAR_W;
  localparam int CNT_W  = 16;

  // Payload bits fill the non-power-of-two positions in ascending order.
  function automatic logic [PAR_W-1:0] data_pos(input int idx);
    int              cnt;
    logic [PAR_W-1:0] pos;
    cnt = 0;
    pos = '0;
    for (int p = 1; p <= CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = PAR_W'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  // Positions whose index has bit j set.
  function automatic logic [CODE_W-1:0] syn_mask(input int j);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int p = 1; p <= CODE_W; p++) begin
      if (((p >> j) & 1) != 0) m = m | (CODE_W'(1) << (p - 1));
    end
    return m;
  endfunction

  function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int j = 0; j < PAR_W; j++) begin
      if (^(cw & syn_mask(j))) s = s | (PAR_W'(1) << j);
    end
    return s;
  endfunction

  // Place data, then set each parity bit so the overall syndrome is zero.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    logic [PAR_W-1:0]  s;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (((d >> i) & DATA_W'(1)) != '0) cw = cw | (CODE_W'(1) << (data_pos(i) - 1'b1));
    end
    s = calc_syndrome(cw);
    for (int j = 0; j < PAR_W; j++) begin
      if (((s >> j) & PAR_W'(1)) != '0) cw = cw | (CODE_W'(1) << ((1 << j) - 1));
    end
    return cw;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// ---------------------------------------------------------------------------
// hamming_syndrome
//   Combinational syndrome generator for the Hamming(21,16) code.
//   Ports:
//     cw_i  [20:0] in   received codeword (bit k-1 = position k)
//     syn_o [4:0]  out  syndrome; 0 = clean, 1..21 = error position
// ---------------------------------------------------------------------------
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] cw_i,
  output logic [PAR_W-1:0]  syn_o
);

  genvar gi;
  generate
    for (gi = 0; gi < PAR_W; gi++) begin : g_syn
      // Coverage mask includes the parity bit itself, so a clean word gives 0.
      localparam logic [CODE_W-1:0] MASK = syn_mask(gi);
      assign syn_o[gi] = ^(cw_i & MASK);
    end
  endgenerate

endmodule

// File: rtl/hamming_dec.sv
// ---------------------------------------------------------------------------
// hamming_dec
//   Hamming(21,16) single-error-correcting decoder, 2-stage valid/ready
//   pipeline sustaining one word per cycle.
//   Stage 1 registers the raw payload bits and the syndrome; stage 2 applies
//   the correction and drives the output registers.
//   Ports:
//     clk      in        rising-edge clock
//     rst      in        asynchronous active-low reset
//     iData    in  [20:0] received codeword (bit k-1 = position k)
//     iValid   in        upstream word valid
//     oReady   out       decoder accepts iData this cycle
//     oData    out [15:0] corrected payload
//     oCorr    out       single-bit error was corrected (with oValid)
//     oUncorr  out       syndrome 22..31, payload passed raw (with oValid)
//     oValid   out       output word valid
//     iReady   in        downstream accepts output this cycle
//   Optional (macro HAMMING_DEC_STATS_EN):
//     iClrCnt    in        clear both counters (wins over increment)
//     oCorrCnt   out [15:0] saturating count of corrected words delivered
//     oUncorrCnt out [15:0] saturating count of uncorrectable words delivered
// ---------------------------------------------------------------------------
module hamming_dec
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  output logic [DATA_W-1:0] oData,
  output logic              oCorr,
  output logic              oUncorr,
  output logic              oValid,
  input  logic              iReady
`ifdef HAMMING_DEC_STATS_EN
  ,
  input  logic              iClrCnt,
  output logic [CNT_W-1:0]  oCorrCnt,
  output logic [CNT_W-1:0]  oUncorrCnt
`endif
);

  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CODE_W);

  logic              ld1;
  logic              ld2;
  logic [DATA_W-1:0] data_raw;
  logic [PAR_W-1:0]  syn_in;
  logic [DATA_W-1:0] flip;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [PAR_W-1:0]  s1_syn_q,   s1_syn_d;

  logic              o_valid_q,  o_valid_d;
  logic [DATA_W-1:0] o_data_q,   o_data_d;
  logic              o_corr_q,   o_corr_d;
  logic              o_uncorr_q, o_uncorr_d;

  hamming_syndrome u_syndrome (
    .cw_i  (iData),
    .syn_o (syn_in)
  );

  // Parity positions are only needed for the syndrome, so stage 1 keeps just
  // the payload bits. A syndrome pointing at a parity position matches no
  // flip bit, which leaves the payload untouched as intended.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_data
      localparam logic [PAR_W-1:0] POS = data_pos(gi);
      assign data_raw[gi] = iData[POS - 1'b1];
      assign flip[gi]     = (s1_syn_q == POS);
    end
  endgenerate

  // Each stage loads when its downstream slot is empty or being drained;
  // this gives full throughput at the cost of a combinational iReady->oReady path.
  assign ld2    = !o_valid_q || iReady;
  assign ld1    = !s1_valid_q || ld2;
  assign oReady = ld1;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    if (ld1) begin
      s1_valid_d = iValid;
      if (iValid) begin
        s1_data_d = data_raw;
        s1_syn_d  = syn_in;
      end
    end
  end

  always_comb begin
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_corr_d   = o_corr_q;
    o_uncorr_d = o_uncorr_q;
    if (ld2) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_data_d   = s1_data_q ^ flip;
        o_corr_d   = (s1_syn_q != '0) && (s1_syn_q <= MAX_POS);
        o_uncorr_d = (s1_syn_q > MAX_POS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_corr_q   <= 1'b0;
      o_uncorr_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_syn_q   <= s1_syn_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_corr_q   <= o_corr_d;
      o_uncorr_q <= o_uncorr_d;
    end
  end

  assign oData   = o_data_q;
  assign oCorr   = o_corr_q;
  assign oUncorr = o_uncorr_q;
  assign oValid  = o_valid_q;

`ifdef HAMMING_DEC_STATS_EN
  logic             out_xfer;
  logic [CNT_W-1:0] corr_cnt_q,   corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  assign out_xfer = o_valid_q && iReady;

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (iClrCnt) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_xfer) begin
      if (o_corr_q && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + 1'b1;
      if (o_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign oCorrCnt   = corr_cnt_q;
  assign oUncorrCnt = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_dec.sv
// Scoreboard bench for hamming_dec: the driver pushes the reference model's
// answer for every accepted codeword, the monitor pops on each output transfer.
module tb_hamming_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [20:0] iData = '0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [15:0] oData;
  logic        oCorr;
  logic        oUncorr;
  logic        oValid;
  logic        iReady = 1'b0;
`ifdef HAMMING_DEC_STATS_EN
  logic        iClrCnt = 1'b0;
  logic [15:0] oCorrCnt;
  logic [15:0] oUncorrCnt;
`endif

  always #5 clk = ~clk;

  hamming_dec dut (
    .clk     (clk),
    .rst     (rst),
    .iData   (iData),
    .iValid  (iValid),
    .oReady  (oReady),
    .oData   (oData),
    .oCorr   (oCorr),
    .oUncorr (oUncorr),
    .oValid  (oValid),
    .iReady  (iReady)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .iClrCnt    (iClrCnt),
    .oCorrCnt   (oCorrCnt),
    .oUncorrCnt (oUncorrCnt)
`endif
  );

  typedef struct {
    logic [15:0] data;
    logic        corr;
    logic        uncorr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   hold_cnt = 0;
  bit   rand_ready = 0;
  bit   saw_not_ready = 0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_out = '0;
  logic [15:0] m_corr = '0;
  logic [15:0] m_uncorr = '0;

  // ---------------- reference model ----------------
  function automatic bit is_pow2(int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic bit cw_bit(logic [20:0] cw, int p);
    return ((cw >> (p - 1)) & 21'd1) != 21'd0;
  endfunction

  // Syndrome = XOR of the position numbers of every set bit.
  function automatic int ref_syndrome(logic [20:0] cw);
    int s = 0;
    for (int p = 1; p <= 21; p++) if (cw_bit(cw, p)) s = s ^ p;
    return s;
  endfunction

  function automatic exp_t model(logic [20:0] cw);
    exp_t        e;
    int          s;
    int          k;
    logic [20:0] fixed;
    s = ref_syndrome(cw);
    fixed = cw;
    e.corr = (s >= 1) && (s <= 21);
    e.uncorr = (s > 21);
    if (e.corr) fixed = cw ^ (21'd1 << (s - 1));
    e.data = '0;
    k = 0;
    for (int p = 1; p <= 21; p++) begin
      if (!is_pow2(p)) begin
        if (cw_bit(fixed, p)) e.data = e.data | (16'd1 << k);
        k++;
      end
    end
    return e;
  endfunction

  function automatic logic [20:0] ref_encode(logic [15:0] d);
    logic [20:0] cw = '0;
    int k = 0;
    int s;
    for (int p = 1; p <= 21; p++) begin
      if (!is_pow2(p)) begin
        if (((d >> k) & 16'd1) != 16'd0) cw = cw | (21'd1 << (p - 1));
        k++;
      end
    end
    s = ref_syndrome(cw);
    for (int j = 0; j < 5; j++) if (((s >> j) & 1) != 0) cw = cw | (21'd1 << ((1 << j) - 1));
    return cw;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // ---------------- downstream ready ----------------
  always @(posedge clk) begin
    #1;
    if (hold_cnt > 0) begin
      iReady = 1'b0;
      hold_cnt--;
    end else begin
      iReady = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      m_corr = '0;
      m_uncorr = '0;
    end else begin
      if (prev_stall) check("stall_hold", {13'd0, oValid, oCorr, oUncorr, oData}, {13'd0, prev_out});
      prev_stall = oValid && !iReady;
      prev_out = {oValid, oCorr, oUncorr, oData};
      if (oValid && iReady) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got data 0x%0h, expected no output", oData);
        end else begin
          mon_e = exp_q.pop_front();
          check("data", {16'd0, oData}, {16'd0, mon_e.data});
          check("corr", {31'd0, oCorr}, {31'd0, mon_e.corr});
          check("uncorr", {31'd0, oUncorr}, {31'd0, mon_e.uncorr});
`ifdef HAMMING_DEC_STATS_EN
          check("corr_cnt", {16'd0, oCorrCnt}, {16'd0, m_corr});
          check("uncorr_cnt", {16'd0, oUncorrCnt}, {16'd0, m_uncorr});
          if (mon_e.corr && m_corr != 16'hFFFF) m_corr++;
          if (mon_e.uncorr && m_uncorr != 16'hFFFF) m_uncorr++;
`endif
        end
      end
`ifdef HAMMING_DEC_STATS_EN
      if (iClrCnt) begin
        m_corr = '0;
        m_uncorr = '0;
      end
`endif
    end
  end

  // ---------------- driver ----------------
  // Called and returns at posedge+1.
  task automatic send(input logic [20:0] cw);
    int w = 0;
    iData = cw;
    iValid = 1'b1;
    @(negedge clk);
    while (!oReady && w < 200) begin
      saw_not_ready = 1;
      w++;
      @(negedge clk);
    end
    if (!oReady) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: oReady stayed 0, expected 1 within 200 cycles");
    end else begin
      exp_q.push_back(model(cw));
    end
    @(posedge clk);
    #1;
    iValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      idle(1);
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic [15:0] d;
  logic [20:0] cw;
  int          kind;
  int          p1;
  int          p2;

  initial begin
    // Reset and post-reset state.
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_oValid", {31'd0, oValid}, 32'd0);
    check("rst_oReady", {31'd0, oReady}, 32'd1);
    check("rst_oData", {16'd0, oData}, 32'd0);
    check("rst_oCorr", {31'd0, oCorr}, 32'd0);
    check("rst_oUncorr", {31'd0, oUncorr}, 32'd0);
    @(posedge clk);
    #1;

    // Clean zero word, latency of two edges.
    send(21'h0);
    @(negedge clk);
    check("lat_edge1_oValid", {31'd0, oValid}, 32'd0);
    @(negedge clk);
    check("lat_edge2_oValid", {31'd0, oValid}, 32'd1);
    @(posedge clk);
    #1;

    // Data-position error, parity-position error, uncorrectable (S=22).
    send(21'h000010);
    send(21'h000001);
    send((21'd1 << 6) | (21'd1 << 16));
    drain();

    // Backpressure with four back-to-back words.
    hold_cnt = 6;
    idle(1);
    saw_not_ready = 0;
    for (int i = 0; i < 4; i++) send(ref_encode(16'(i * 16'h1111 + 16'h0A05)));
    check("bp_oReady_dropped", {31'd0, saw_not_ready}, 32'd1);
    drain();

    // Randomised traffic with random downstream stalls.
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      d = 16'($urandom);
      cw = ref_encode(d);
      kind = $urandom_range(0, 9);
      p1 = $urandom_range(1, 21);
      p2 = $urandom_range(1, 21);
      if (kind < 4) cw = cw ^ (21'd1 << (p1 - 1));
      else if (kind == 4 && p1 != p2) cw = cw ^ (21'd1 << (p1 - 1)) ^ (21'd1 << (p2 - 1));
      else if (kind == 5) cw = 21'($urandom);
      send(cw);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
    end

    // Roundtrip: every single-bit flip of encoded random data.
    for (int n = 0; n < 4; n++) begin
      d = 16'($urandom);
      for (int k = 0; k < 21; k++) send(ref_encode(d) ^ (21'd1 << k));
    end
    rand_ready = 0;
    drain();

    // Reset with two words in flight.
    hold_cnt = 8;
    idle(1);
    send(ref_encode(16'h1234));
    send(ref_encode(16'h5678) ^ 21'h4);
    #2 rst = 1'b0;
    #1;
    check("inflight_rst_oValid", {31'd0, oValid}, 32'd0);
    check("inflight_rst_oData", {16'd0, oData}, 32'd0);
    hold_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("post_rst_oValid", {31'd0, oValid}, 32'd0);
    check("post_rst_oReady", {31'd0, oReady}, 32'd1);
    @(posedge clk);
    #1;

`ifdef HAMMING_DEC_STATS_EN
    for (int n = 0; n < 3; n++) begin
      p1 = $urandom_range(0, 20);
      send(ref_encode(16'($urandom)) ^ (21'd1 << p1));
    end
    drain();
    idle(1);
    check("stats_corr_3", {16'd0, oCorrCnt}, 32'd3);
    check("stats_uncorr_0", {16'd0, oUncorrCnt}, 32'd0);
    iClrCnt = 1'b1;
    idle(1);
    iClrCnt = 1'b0;
    @(negedge clk);
    check("stats_clr_corr", {16'd0, oCorrCnt}, 32'd0);
    @(posedge clk);
    #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
